// File: rtl/maindec_pipe_if.sv
// ID-stage decode request and pipelined control-word results of maindec_pipe.
// The master side issues instructions and pipeline control; the slave side is the decoder.
interface maindec_pipe_if #(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
);
  logic                    id_valid;
  logic [5:0]              op;
  logic [5:0]              funct;
  logic                    stall;
  logic                    flush;
  logic                    hold;
  logic [8*PIPE_DEPTH-1:0] cw_q;
  logic [PIPE_DEPTH-1:0]   valid_q;
  logic                    illegal_e;
  logic [CNT_W-1:0]        illegal_cnt;

  modport master (
    output id_valid, op, funct, stall, flush, hold,
    input  cw_q, valid_q, illegal_e, illegal_cnt
  );

  modport slave (
    input  id_valid, op, funct, stall, flush, hold,
    output cw_q, valid_q, illegal_e, illegal_cnt
  );
endinterface

// File: rtl/maindec_pipe.sv
// MIPS main decoder feeding a chain of control-word pipeline registers
// with bubble insertion, global hold, deferred flush and an illegal-op counter.
module maindec_pipe #(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  maindec_pipe_if.slave  bus
);

  // Returns {illegal, cw}; cw bits are regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump,link.
  function automatic logic [8:0] decode(input logic vld, input logic [5:0] op,
                                        input logic [5:0] funct);
    logic [8:0] r;
    r = 9'h100;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
          6'b100111, 6'b101010, 6'b000000, 6'b000010: r = 9'h0C0;
          default:                                    r = 9'h100;
        endcase
      end
      6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b001000: r = 9'h0A0;
      6'b100011: r = 9'h0A4;
      6'b101011: r = 9'h028;
      6'b000100, 6'b000101: r = 9'h010;
      6'b000010: r = 9'h002;
      6'b000011: r = 9'h083;
      default:   r = 9'h100;
    endcase
    if (!vld) r = 9'h000;
    return r;
  endfunction

  logic [7:0]            cw_p [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] vld_p;
  logic                  ill_p0;
  logic                  flush_pend;
  logic [CNT_W-1:0]      cnt;
  logic [8:0]            dec;
  logic                  bubble;
  logic                  count_en;

  assign dec      = decode(bus.id_valid, bus.op, bus.funct);
  assign bubble   = bus.stall | bus.flush | flush_pend;
  assign count_en = !bus.hold && !bubble && dec[8] && (cnt != {CNT_W{1'b1}});

  // Stage 0 (EX) load and downstream shift; hold freezes the whole chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) cw_p[k] <= 8'h00;
      vld_p  <= '0;
      ill_p0 <= 1'b0;
    end else if (!bus.hold) begin
      if (bubble) begin
        cw_p[0]  <= 8'h00;
        vld_p[0] <= 1'b0;
        ill_p0   <= 1'b0;
      end else begin
        cw_p[0]  <= dec[7:0];
        vld_p[0] <= bus.id_valid;
        ill_p0   <= dec[8];
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        cw_p[k]  <= cw_p[k-1];
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // A flush seen during hold is replayed as a bubble on the first non-hold cycle.
  always_ff @(posedge clk) begin
    if (rst)           flush_pend <= 1'b0;
    else if (bus.hold) flush_pend <= flush_pend | bus.flush;
    else               flush_pend <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)           cnt <= '0;
    else if (count_en) cnt <= cnt + 1'b1;
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_out
    assign bus.cw_q[8*k +: 8] = cw_p[k];
  end
  assign bus.valid_q     = vld_p;
  assign bus.illegal_e   = ill_p0 & vld_p[0];
  assign bus.illegal_cnt = cnt;

endmodule

// File: tb/tb_maindec_pipe.sv
// Scoreboard bench for maindec_pipe: a wide-counter and a 2-bit-counter instance
// share stimulus; a table-driven reference model predicts every cycle's outputs.
module tb_maindec_pipe;
  localparam int PD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maindec_pipe_if #(.PIPE_DEPTH(PD), .CNT_W(16)) bus ();
  maindec_pipe_if #(.PIPE_DEPTH(PD), .CNT_W(2))  bus2 ();

  maindec_pipe #(.PIPE_DEPTH(PD), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus.slave));
  maindec_pipe #(.PIPE_DEPTH(PD), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    logic [8*PD-1:0] cw;
    logic [PD-1:0]   v;
    logic            ill;
    logic [15:0]     c16;
    logic [1:0]      c2;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ncyc   = 0;

  // Reference model state: a shift register of words plus plain integer counters.
  logic [7:0]  m_cw [PD];
  logic [PD-1:0] m_v;
  bit          m_ill;
  bit          m_pend;
  int          m_c16;
  int          m_c2;

  logic [7:0]  op_tab [bit [5:0]];
  logic [5:0]  rfun [$];
  logic [5:0]  ops_legal [$];

  localparam logic [5:0] ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011, JAL = 6'b000011;
  localparam logic [5:0] RTY = 6'b000000, F_ADD = 6'b100000;

  function automatic void ref_decode(input logic [5:0] o, input logic [5:0] fn,
                                     output logic [7:0] cw, output bit ill);
    ill = 1'b1;
    cw  = 8'h00;
    if (o == 6'b000000) begin
      foreach (rfun[i]) if (rfun[i] == fn) ill = 1'b0;
      if (!ill) cw = 8'hC0;
    end else if (op_tab.exists(o)) begin
      ill = 1'b0;
      cw  = op_tab[o];
    end
  endfunction

  task automatic chk(input string nm, input int cy, input logic [31:0] act, input logic [31:0] exq);
    n_chk++;
    if (act !== exq) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cy, act, exq);
    end
  endtask

  task automatic cyc(input logic r, input logic h, input logic s, input logic f,
                     input logic iv, input logic [5:0] o, input logic [5:0] fn);
    exp_t e;
    logic [7:0] dcw;
    bit dill;
    bit bub;
    @(negedge clk);
    rst = r;
    bus.hold = h;      bus2.hold = h;
    bus.stall = s;     bus2.stall = s;
    bus.flush = f;     bus2.flush = f;
    bus.id_valid = iv; bus2.id_valid = iv;
    bus.op = o;        bus2.op = o;
    bus.funct = fn;    bus2.funct = fn;
    ref_decode(o, fn, dcw, dill);
    if (r) begin
      for (int k = 0; k < PD; k++) m_cw[k] = 8'h00;
      m_v = '0; m_ill = 0; m_pend = 0; m_c16 = 0; m_c2 = 0;
    end else if (h) begin
      m_pend = m_pend | f;
    end else begin
      bub = s | f | m_pend;
      m_pend = 0;
      for (int k = PD - 1; k > 0; k--) begin
        m_cw[k] = m_cw[k-1];
        m_v[k]  = m_v[k-1];
      end
      if (bub) begin
        m_cw[0] = 8'h00; m_v[0] = 1'b0; m_ill = 0;
      end else begin
        m_cw[0] = iv ? dcw : 8'h00;
        m_v[0]  = iv;
        m_ill   = iv && dill;
        if (m_ill) begin
          if (m_c16 < 65535) m_c16++;
          if (m_c2 < 3)      m_c2++;
        end
      end
    end
    for (int k = 0; k < PD; k++) e.cw[8*k +: 8] = m_cw[k];
    e.v   = m_v;
    e.ill = m_ill && m_v[0];
    e.c16 = 16'(m_c16);
    e.c2  = 2'(m_c2);
    e.cyc = ncyc;
    sb.push_back(e);
    ncyc++;
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] fn);
    cyc(0, 0, 0, 0, 1, o, fn);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cw_q",          e.cyc, 32'(bus.cw_q),        32'(e.cw));
        chk("valid_q",       e.cyc, 32'(bus.valid_q),     32'(e.v));
        chk("illegal_e",     e.cyc, 32'(bus.illegal_e),   32'(e.ill));
        chk("illegal_cnt",   e.cyc, 32'(bus.illegal_cnt), 32'(e.c16));
        chk("sat_cw_q",      e.cyc, 32'(bus2.cw_q),       32'(e.cw));
        chk("sat_illegal_e", e.cyc, 32'(bus2.illegal_e),  32'(e.ill));
        chk("sat_cnt",       e.cyc, 32'(bus2.illegal_cnt), 32'(e.c2));
      end
    end
  end

  initial begin : driver
    logic [5:0] o, fn;
    bus.hold = 0;  bus.stall = 0;  bus.flush = 0;  bus.id_valid = 0;  bus.op = 0;  bus.funct = 0;
    bus2.hold = 0; bus2.stall = 0; bus2.flush = 0; bus2.id_valid = 0; bus2.op = 0; bus2.funct = 0;
    op_tab[6'b001100] = 8'hA0; op_tab[6'b001101] = 8'hA0; op_tab[6'b001110] = 8'hA0;
    op_tab[6'b001111] = 8'hA0; op_tab[6'b001000] = 8'hA0; op_tab[6'b100011] = 8'hA4;
    op_tab[6'b101011] = 8'h28; op_tab[6'b000100] = 8'h10; op_tab[6'b000101] = 8'h10;
    op_tab[6'b000010] = 8'h02; op_tab[6'b000011] = 8'h83;
    rfun = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
             6'b100111, 6'b101010, 6'b000000, 6'b000010};
    ops_legal = '{6'b000000, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b001000,
                  6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011};

    // Reset then stream
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    issue(ORI, 0); issue(LW, 0); issue(SW, 0); issue(JAL, 0);
    cyc(0, 0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0);
    // Stall while ADD is in ID
    issue(RTY, F_ADD);
    cyc(0, 0, 1, 0, 1, RTY, F_ADD);
    issue(RTY, F_ADD);
    cyc(0, 0, 1, 1, 1, RTY, F_ADD);
    // Hold with flush in the second hold cycle
    issue(ORI, 0); issue(LW, 0); issue(SW, 0);
    cyc(0, 1, 0, 0, 1, JAL, 0);
    cyc(0, 1, 0, 1, 1, JAL, 0);
    cyc(0, 1, 1, 0, 1, JAL, 0);
    issue(JAL, 0); issue(RTY, F_ADD); issue(LW, 0);
    // Illegal encodings, with and without id_valid
    issue(6'b111111, 0);
    issue(RTY, 6'b001111);
    cyc(0, 0, 0, 0, 0, 6'b111111, 0);
    cyc(0, 0, 0, 0, 0, RTY, 6'b001111);
    cyc(0, 0, 1, 0, 1, 6'b111111, 0);
    cyc(0, 1, 0, 0, 1, 6'b111111, 0);
    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) issue(6'b110011, 0);
    // Reset during hold with all stages valid
    issue(ORI, 0); issue(LW, 0); issue(SW, 0);
    cyc(1, 1, 0, 0, 1, JAL, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) < 7) o = ops_legal[$urandom_range(ops_legal.size() - 1)];
      else                       o = 6'($urandom);
      if ($urandom_range(9) < 6) fn = rfun[$urandom_range(rfun.size() - 1)];
      else                       fn = 6'($urandom);
      cyc(($urandom_range(99) == 0), ($urandom_range(5) == 0), ($urandom_range(9) == 0),
          ($urandom_range(9) == 0), ($urandom_range(9) < 8), o, fn);
    end

    @(posedge clk);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
